// File: rtl/getreg_abi_name_if.sv
// Request/response bundle for the RISC-V register index <-> ABI name lookup.
// Requester drives req_*, the lookup block drives rsp_*.
interface getreg_abi_name_if #(
    parameter int NAME_W = 32
);
    logic              req_valid;
    logic              req_rev;
    logic [5:0]        req_idx;
    logic [NAME_W-1:0] req_name;
    logic              rsp_valid;
    logic [NAME_W-1:0] rsp_name;
    logic [4:0]        rsp_idx;
    logic              rsp_err;

    modport master (
        output req_valid, req_rev, req_idx, req_name,
        input  rsp_valid, rsp_name, rsp_idx, rsp_err
    );

    modport slave (
        input  req_valid, req_rev, req_idx, req_name,
        output rsp_valid, rsp_name, rsp_idx, rsp_err
    );
endinterface

// File: rtl/getreg_abi_name.sv
// Clocked lookup between RISC-V integer register indices and packed ASCII ABI names.
// Combinational decode of the request feeds a single registered response stage.
module getreg_abi_name #(
    parameter int NAME_W = 32
) (
    input logic clk,
    input logic reset,
    getreg_abi_name_if.slave bus
);

    // Names are right-justified: first character in the most significant used byte.
    function automatic logic [31:0] canon_name(input logic [4:0] idx);
        logic [31:0] n;
        case (idx)
            5'd0:  n = 32'h7A65_726F; // zero
            5'd1:  n = 32'h0000_7261; // ra
            5'd2:  n = 32'h0000_7370; // sp
            5'd3:  n = 32'h0000_6770; // gp
            5'd4:  n = 32'h0000_7470; // tp
            5'd5:  n = 32'h0000_7430; // t0
            5'd6:  n = 32'h0000_7431;
            5'd7:  n = 32'h0000_7432;
            5'd8:  n = 32'h0000_7330; // s0
            5'd9:  n = 32'h0000_7331;
            5'd10: n = 32'h0000_6130; // a0
            5'd11: n = 32'h0000_6131;
            5'd12: n = 32'h0000_6132;
            5'd13: n = 32'h0000_6133;
            5'd14: n = 32'h0000_6134;
            5'd15: n = 32'h0000_6135;
            5'd16: n = 32'h0000_6136;
            5'd17: n = 32'h0000_6137;
            5'd18: n = 32'h0000_7332; // s2
            5'd19: n = 32'h0000_7333;
            5'd20: n = 32'h0000_7334;
            5'd21: n = 32'h0000_7335;
            5'd22: n = 32'h0000_7336;
            5'd23: n = 32'h0000_7337;
            5'd24: n = 32'h0000_7338;
            5'd25: n = 32'h0000_7339;
            5'd26: n = 32'h0073_3130; // s10
            5'd27: n = 32'h0073_3131; // s11
            5'd28: n = 32'h0000_7433; // t3
            5'd29: n = 32'h0000_7434;
            5'd30: n = 32'h0000_7435;
            default: n = 32'h0000_7436; // t6
        endcase
        return n;
    endfunction

    // Architectural name "xN" in decimal without leading zeros.
    function automatic logic [31:0] arch_name(input logic [4:0] idx);
        logic [7:0] tens;
        logic [7:0] ones;
        tens = 8'h30 + 8'(idx / 5'd10);
        ones = 8'h30 + 8'(idx % 5'd10);
        if (idx < 5'd10)
            return {16'h0000, 8'h78, ones};
        else
            return {8'h00, 8'h78, tens, ones};
    endfunction

    localparam logic [31:0] FP_ALIAS = 32'h0000_6670;

    logic              nxt_err;
    logic [4:0]        nxt_idx;
    logic [NAME_W-1:0] nxt_name;

    always_comb begin
        nxt_err  = 1'b1;
        nxt_idx  = '0;
        nxt_name = '0;
        if (!bus.req_rev) begin
            nxt_idx = bus.req_idx[4:0];
            nxt_err = bus.req_idx[5];
            if (!bus.req_idx[5])
                nxt_name = NAME_W'(canon_name(bus.req_idx[4:0]));
        end else begin
            // Exact match on all bits, so case, justification and padding errors all miss.
            for (int unsigned i = 0; i < 32; i++) begin
                if (bus.req_name == NAME_W'(canon_name(5'(i))) ||
                    bus.req_name == NAME_W'(arch_name(5'(i)))) begin
                    nxt_err = 1'b0;
                    nxt_idx = 5'(i);
                end
            end
            if (bus.req_name == NAME_W'(FP_ALIAS)) begin
                nxt_err = 1'b0;
                nxt_idx = 5'd8;
            end
            if (!nxt_err)
                nxt_name = NAME_W'(canon_name(nxt_idx));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_name  <= '0;
            bus.rsp_idx   <= '0;
            bus.rsp_err   <= 1'b0;
        end else if (bus.req_valid) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_name  <= nxt_name;
            bus.rsp_idx   <= nxt_idx;
            bus.rsp_err   <= nxt_err;
        end else begin
            bus.rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_getreg_abi_name.sv
// Self-checking bench for getreg_abi_name: table-driven vectors with a response scoreboard.
module tb_getreg_abi_name;

    typedef struct {
        logic        valid;
        logic [31:0] name;
        logic [4:0]  idx;
        logic        err;
    } rsp_t;

    typedef struct {
        string       tag;
        logic        rev;
        logic [5:0]  idx;
        logic [31:0] name;
        rsp_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    getreg_abi_name_if #(.NAME_W(32)) bus ();

    getreg_abi_name #(.NAME_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    string abi [32] = '{"zero","ra","sp","gp","tp","t0","t1","t2","s0","s1",
                        "a0","a1","a2","a3","a4","a5","a6","a7",
                        "s2","s3","s4","s5","s6","s7","s8","s9","s10","s11",
                        "t3","t4","t5","t6"};

    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t sb[$];
    rsp_t last;
    vec_t vecs[$];

    function automatic logic [31:0] pack(input string s);
        logic [31:0] r = '0;
        for (int i = 0; i < s.len(); i++) r = {r[23:0], s[i]};
        return r;
    endfunction

    function automatic rsp_t ok(input int i);
        rsp_t r;
        r.valid = 1'b1; r.name = pack(abi[i]); r.idx = 5'(i); r.err = 1'b0;
        return r;
    endfunction

    function automatic rsp_t bad(input logic [4:0] i);
        rsp_t r;
        r.valid = 1'b1; r.name = '0; r.idx = i; r.err = 1'b1;
        return r;
    endfunction

    function automatic vec_t mk(input string tag, input logic rev, input logic [5:0] idx,
                                input logic [31:0] name, input rsp_t exp);
        vec_t v;
        v.tag = tag; v.rev = rev; v.idx = idx; v.name = name; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask

    // Drive one cycle of stimulus, push its expected response, compare after the edge.
    task automatic step(input string tag, input logic rst, input logic vld, input logic rev,
                        input logic [5:0] idx, input logic [31:0] name, input rsp_t exp);
        rsp_t e;
        @(negedge clk);
        reset         = rst;
        bus.req_valid = vld;
        bus.req_rev   = rev;
        bus.req_idx   = idx;
        bus.req_name  = name;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ".valid"}, 32'(bus.rsp_valid), 32'(e.valid));
        check({tag, ".name"},  bus.rsp_name,       e.name);
        check({tag, ".idx"},   32'(bus.rsp_idx),   32'(e.idx));
        check({tag, ".err"},   32'(bus.rsp_err),   32'(e.err));
        last = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        rsp_t zero_r;
        rsp_t hold;
        zero_r = '{valid: 1'b0, name: '0, idx: '0, err: 1'b0};

        for (int i = 0; i < 32; i++)
            vecs.push_back(mk($sformatf("fwd%0d", i), 1'b0, 6'(i), '0, ok(i)));
        vecs.push_back(mk("fwd40", 1'b0, 6'd40, '0, bad(5'd8)));
        vecs.push_back(mk("fwd63", 1'b0, 6'd63, '0, bad(5'd31)));
        vecs.push_back(mk("fwd32", 1'b0, 6'd32, '0, bad(5'd0)));
        vecs.push_back(mk("rev_a0",   1'b1, '0, 32'h0000_6130, ok(10)));
        vecs.push_back(mk("rev_fp",   1'b1, '0, pack("fp"),    ok(8)));
        vecs.push_back(mk("rev_x31",  1'b1, '0, 32'h0078_3331, ok(31)));
        vecs.push_back(mk("rev_zero", 1'b1, '0, pack("zero"),  ok(0)));
        vecs.push_back(mk("rev_s11",  1'b1, '0, pack("s11"),   ok(27)));
        vecs.push_back(mk("rev_t6",   1'b1, '0, pack("t6"),    ok(31)));
        vecs.push_back(mk("rev_RA",   1'b1, 6'd5, 32'h0000_5241, bad(5'd0)));
        vecs.push_back(mk("rev_x32",  1'b1, '0, pack("x32"),   bad(5'd0)));
        vecs.push_back(mk("rev_x05",  1'b1, '0, pack("x05"),   bad(5'd0)));
        vecs.push_back(mk("rev_ljust", 1'b1, '0, 32'h7261_0000, bad(5'd0)));
        vecs.push_back(mk("rev_pad",  1'b1, '0, 32'h2020_7261, bad(5'd0)));
        for (int i = 0; i < 32; i++)
            vecs.push_back(mk($sformatf("rev_x%0d", i), 1'b1, '0,
                              pack($sformatf("x%0d", i)), ok(i)));

        bus.req_valid = 1'b0; bus.req_rev = 1'b0; bus.req_idx = '0; bus.req_name = '0;

        // Reset held for two edges with a live request: the request must be dropped.
        step("rst0", 1'b1, 1'b1, 1'b0, 6'd1, '0, zero_r);
        step("rst1", 1'b1, 1'b1, 1'b0, 6'd2, '0, zero_r);

        foreach (vecs[k])
            step(vecs[k].tag, 1'b0, 1'b1, vecs[k].rev, vecs[k].idx, vecs[k].name, vecs[k].exp);

        // Idle after a response: valid drops, payload holds.
        step("pre_idle", 1'b0, 1'b1, 1'b0, 6'd26, '0, ok(26));
        hold = last; hold.valid = 1'b0;
        step("idle0", 1'b0, 1'b0, 1'b1, 6'd3, pack("ra"), hold);
        step("idle1", 1'b0, 1'b0, 1'b0, 6'd40, '0, hold);

        // Reset colliding with a request clears everything.
        step("pre_rst", 1'b0, 1'b1, 1'b1, '0, pack("gp"), ok(3));
        step("rst_mid", 1'b1, 1'b1, 1'b0, 6'd7, '0, zero_r);
        step("post_rst", 1'b0, 1'b1, 1'b0, 6'd7, '0, ok(7));

        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/getreg_abi_name.md
Name: getreg_abi_name

Overview:
- Clocked lookup between RISC-V integer register indices (x0–x31) and their ABI mnemonic names, packed as ASCII.
- Used by the execute stage and debug/trace tasks to print register names next to register contents.
- Supports forward lookup (index→name) and reverse lookup (name→index).
- Registered result, one-cycle latency.

Parameters:
- NAME_W, 32, width of the packed ASCII name bus; 4 characters, 8 bits each.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  lookup request is present this cycle.
- req_rev  input  1  lookup direction: 0 = index→name, 1 = name→index.
- req_idx  input  6  register index for forward lookup; matches the 6-bit dest-reg field.
- req_name  input  NAME_W  packed ASCII name for reverse lookup.
- rsp_valid  output  1  response registered this cycle.
- rsp_name  output  NAME_W  canonical ABI name, packed.
- rsp_idx  output  5  register index.
- rsp_err  output  1  request could not be resolved.

Behaviour:
- Reset:
  - reset=1 at a rising edge clears rsp_valid, rsp_name, rsp_idx and rsp_err to 0.
  - Reset has priority over a simultaneous request; that request is dropped.
- Latency and handshake:
  - A request sampled with req_valid=1 produces its response on the next edge, with rsp_valid=1 for exactly one cycle.
  - No backpressure; one request can be accepted every cycle.
  - When req_valid=0, rsp_valid goes to 0 and the other outputs hold their last values.
- Name packing:
  - Names are right-justified, one ASCII byte per character, first character in the most significant used byte.
  - Unused upper bytes are 0x00, so %s-style printing strips them.
  - Examples: "ra" = 32'h0000_7261; "zero" = 32'h7A65_726F; "s10" = 32'h0073_3130.
- Canonical table (index: name):
  - 0 zero, 1 ra, 2 sp, 3 gp, 4 tp.
  - 5–7 t0–t2.
  - 8 s0, 9 s1.
  - 10–17 a0–a7.
  - 18–27 s2–s11.
  - 28–31 t3–t6.
- Forward lookup (req_rev=0):
  - req_idx 0–31: rsp_idx=req_idx[4:0], rsp_name=table entry, rsp_err=0.
  - req_idx 32–63: rsp_err=1, rsp_name=0, rsp_idx=req_idx[4:0].
- Reverse lookup (req_rev=1):
  - req_name matches a canonical name, the alias "fp" (→8), or an architectural name "x0"–"x31": rsp_idx=the index, rsp_name=that index's canonical name, rsp_err=0.
  - Matching is exact on all NAME_W bits: upper-case letters, left-justified packing, nonzero padding and leading zeros (e.g. "x05") all fail.
  - Failure: rsp_err=1, rsp_idx=0, rsp_name=0.
- Purely combinational decode feeding one output register stage; no other internal state.

Test Plan:
- Reset: assert reset for 2 cycles with req_valid=1 → rsp_valid=0, rsp_name=0, rsp_idx=0, rsp_err=0 on each of those edges.
- Forward sweep: req_idx 0..31 back-to-back, one per cycle → each response one cycle later, e.g. 0→32'h7A65726F, 2→32'h00007370, 26→32'h00733130, 31→32'h00007436; rsp_err=0 throughout.
- Forward out-of-range: req_idx=40 → rsp_err=1, rsp_name=0, rsp_idx=8.
- Reverse lookups:
  - "a0" (32'h00006130) → rsp_idx=10.
  - "fp" → rsp_idx=8, rsp_name="s0".
  - "x31" (32'h00783331) → rsp_idx=31, rsp_name="t6".
  - "zero" → rsp_idx=0.
- Reverse errors: "RA" (32'h00005241), "x32" and "x05" → rsp_err=1, rsp_idx=0, rsp_name=0.
- Idle and reset mid-stream:
  - req_valid=0 after a response → rsp_valid=0, other outputs hold.
  - reset asserted in the same cycle as a request → request dropped, all outputs 0 on the next edge.
